// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multiply sequencer: FSM state encoding,
// the largest supported settling window and the product width.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int MUL_CYCLES_MAX = 15;
   localparam int PROD_W         = 64;

endpackage

// File: rtl/mul_sequencer_mult.sv
// Mult: combinational 32x32 signed multiplier with a full 64-bit product.
// Behavioural stand-in for the Booth radix-4 / Wallace-tree array with the
// same interface; the sequencer treats it as a multicycle path.
import mul_seq_pkg::*;

module Mult (
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   output logic [PROD_W-1:0] product
);

   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] b_ext;

   // Sign-extend both operands and keep the low 64 bits of the product
   always_comb begin
      a_ext   = {{32{a[31]}}, a};
      b_ext   = {{32{b[31]}}, b};
      product = a_ext * b_ext;
   end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: latches operands, holds them stable for MUL_CYCLES clocks
// while Mult settles, then captures the 64-bit product into hi/lo.
// Optional feature macro: MUL_UNSIGNED_EN adds the is_unsigned port and the
// upper-half correction that turns the signed product into an unsigned one.
import mul_seq_pkg::*;

module mul_sequencer #(
   parameter int MUL_CYCLES = 2,
   parameter int CNT_W      = 4
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
`ifdef MUL_UNSIGNED_EN
   input  logic        is_unsigned,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [PROD_W-1:0]  product;
   logic [31:0]        prod_hi;
`ifdef MUL_UNSIGNED_EN
   logic               uns_q, uns_d;
`endif

   Mult u_mult (
      .a       (a_q),
      .b       (b_q),
      .product (product)
   );

`ifdef MUL_UNSIGNED_EN
   // Unsigned view of the product: add back b (resp. a) into the upper half
   // for every operand whose top bit the signed multiplier read as negative
   always_comb begin
      prod_hi = product[63:32]
              + ((uns_q && a_q[31]) ? b_q : 32'd0)
              + ((uns_q && b_q[31]) ? a_q : 32'd0);
   end
`else
   // Signed-only build: the upper half is taken straight from the multiplier
   always_comb begin
      prod_hi = product[63:32];
   end
`endif

   // Next-state, operand latch, counter and output computation; flush wins
   // over both start and capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef MUL_UNSIGNED_EN
      uns_d   = uns_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (flush) begin
               state_d = IDLE;
            end else if (start) begin
               a_d     = op_a;
               b_d     = op_b;
`ifdef MUL_UNSIGNED_EN
               uns_d   = is_unsigned;
`endif
               cnt_d   = CNT_W'(MUL_CYCLES - 1);
               state_d = WAIT;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d  = cnt_q - CNT_W'(1);
               busy_d = 1'b1;
            end else begin
               hi_d    = prod_hi;
               lo_d    = product[31:0];
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state, operand registers and registered outputs
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MUL_UNSIGNED_EN
         uns_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MUL_UNSIGNED_EN
         uns_q   <= uns_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed and random multiplies
// compared against a plain 64-bit arithmetic reference, plus flush, busy,
// back-to-back and asynchronous reset behaviour.
module tb_mul_sequencer;

   localparam int MC = 2;

   logic        clock = 1'b0;
   logic        clear_n = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        is_unsigned = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   mul_sequencer #(
      .MUL_CYCLES (MC),
      .CNT_W      (4)
   ) dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .start       (start),
      .flush       (flush),
      .op_a        (op_a),
      .op_b        (op_b),
`ifdef MUL_UNSIGNED_EN
      .is_unsigned (is_unsigned),
`endif
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   // Hard stop so a stuck design can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference product from plain 64-bit arithmetic
   function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic u);
      longint sa, sb;
      if (u) return {32'd0, a} * {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_hi"},   64'(hi),   64'(exp_hi));
      checkOutput({tag, "_lo"},   64'(lo),   64'(exp_lo));
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic u);
      start       = 1'b1;
      op_a        = a;
      op_b        = b;
      is_unsigned = u;
   endtask

   // Runs one operation whose request is already on the inputs; optionally
   // keeps start high with scrambled operands during WAIT, and optionally
   // chains the next request into the DONE cycle
   task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic u,
                        input bit hold, input bit chain,
                        input logic [31:0] na, input logic [31:0] nb, input logic nu);
      logic [63:0] p;
      int got;
      p = refProduct(a, b, u);
      @(posedge clock); @(negedge clock);
      checkOutput("accept_busy", 64'(busy), 64'd1);
      checkOutput("accept_done", 64'(done), 64'd0);
      if (hold) begin
         op_a = $urandom;
         op_b = $urandom;
         is_unsigned = ~u;
      end else begin
         start = 1'b0;
      end
      got = -1;
      for (int i = 1; i <= MC + 2; i++) begin
         @(posedge clock); @(negedge clock);
         if (done) begin
            got = i;
            break;
         end
      end
      checkOutput("latency", 64'(got), 64'(MC));
      checkOutput("done_busy", 64'(busy), 64'd0);
      checkOutput("result_hi", 64'(hi), 64'(p[63:32]));
      checkOutput("result_lo", 64'(lo), 64'(p[31:0]));
      exp_hi = p[63:32];
      exp_lo = p[31:0];
      start = 1'b0;
      if (chain) begin
         applyStimulus(na, nb, nu);
      end else begin
         @(posedge clock); @(negedge clock);
         checkIdle("after_done");
      end
   endtask

   task automatic idleCycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); @(negedge clock);
         checkOutput({tag, "_no_done"}, 64'(done), 64'd0);
      end
      checkIdle(tag);
   endtask

   initial begin
      logic [31:0] ra, rb;

      // Asynchronous reset with no clock edge needed
      #1 clear_n = 1'b0;
      #2 checkIdle("reset");
      @(negedge clock);
      clear_n = 1'b1;
      idleCycles("idle", 10);

      // Directed signed multiplies
      applyStimulus(32'd7, 32'hFFFF_FFFD, 1'b0);
      runOp(32'd7, 32'hFFFF_FFFD, 1'b0, 0, 0, '0, '0, 1'b0);
      checkOutput("seven_x_m3_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      checkOutput("seven_x_m3_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
      runOp(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0, '0, '0, 1'b0);
      checkOutput("min_sq_hi", 64'(hi), 64'h0000_0000_4000_0000);
      checkOutput("min_sq_lo", 64'(lo), 64'd0);

      // Random signed operands, some with start held during WAIT
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         applyStimulus(ra, rb, 1'b0);
         runOp(ra, rb, 1'b0, (i % 3) == 0, 0, '0, '0, 1'b0);
      end

      // Start held through WAIT with new operands is ignored
      applyStimulus(32'd123, 32'd456, 1'b0);
      runOp(32'd123, 32'd456, 1'b0, 1, 0, '0, '0, 1'b0);

      // Back-to-back request accepted in the DONE cycle
      applyStimulus(32'd100, 32'hFFFF_FFF9, 1'b0);
      runOp(32'd100, 32'hFFFF_FFF9, 1'b0, 0, 1, 32'd5, 32'd6, 1'b0);
      runOp(32'd5, 32'd6, 1'b0, 0, 0, '0, '0, 1'b0);
      checkOutput("b2b_lo", 64'(lo), 64'd30);

      // Flush in the first WAIT cycle: no done, result retained
      applyStimulus(32'd9, 32'd9, 1'b0);
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      flush = 1'b1;
      @(posedge clock); @(negedge clock);
      flush = 1'b0;
      checkIdle("flush_first_wait");
      idleCycles("flush_first_wait_after", MC + 2);

      // Flush on the capture edge wins over capture
      applyStimulus(32'd1000, 32'd77, 1'b0);
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      repeat (MC - 1) begin
         @(posedge clock); @(negedge clock);
      end
      flush = 1'b1;
      @(posedge clock); @(negedge clock);
      flush = 1'b0;
      checkIdle("flush_capture");
      idleCycles("flush_capture_after", MC + 2);

      // Flush together with start in DONE: back to IDLE, nothing launched
      applyStimulus(32'd3, 32'd4, 1'b0);
      runOp(32'd3, 32'd4, 1'b0, 0, 1, 32'd11, 32'd12, 1'b0);
      flush = 1'b1;
      @(posedge clock); @(negedge clock);
      flush = 1'b0;
      start = 1'b0;
      checkIdle("flush_done");
      idleCycles("flush_done_after", MC + 2);

      // Flush together with start in IDLE: request refused
      applyStimulus(32'd21, 32'd2, 1'b0);
      flush = 1'b1;
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      flush = 1'b0;
      checkIdle("flush_idle");
      idleCycles("flush_idle_after", MC + 2);

      // Asynchronous reset in the middle of WAIT
      applyStimulus(32'd55, 32'd66, 1'b0);
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      #2 clear_n = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      #1 checkIdle("async_reset");
      @(negedge clock);
      clear_n = 1'b1;
      idleCycles("async_reset_after", MC + 2);

      // Normal operation resumes after reset
      applyStimulus(32'd7, 32'hFFFF_FFFD, 1'b0);
      runOp(32'd7, 32'hFFFF_FFFD, 1'b0, 0, 0, '0, '0, 1'b0);

`ifdef MUL_UNSIGNED_EN
      // Unsigned versus signed interpretation of the same operands
      applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1);
      runOp(32'hFFFF_FFFF, 32'd2, 1'b1, 0, 0, '0, '0, 1'b0);
      checkOutput("uns_hi", 64'(hi), 64'd1);
      checkOutput("uns_lo", 64'(lo), 64'h0000_0000_FFFF_FFFE);
      applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0);
      runOp(32'hFFFF_FFFF, 32'd2, 1'b0, 0, 0, '0, '0, 1'b0);
      checkOutput("sgn_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      checkOutput("sgn_lo", 64'(lo), 64'h0000_0000_FFFF_FFFE);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         applyStimulus(ra, rb, 1'b1);
         runOp(ra, rb, 1'b1, (i % 2) == 0, 0, '0, '0, 1'b0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
